le_config_loader: RTL and testbench
===================================

LE_CONFIG_LOADER -- requirements
Module: le_config_loader

Interface
REQ-001 SHALL have parameter LUT_SIZE, default 16, giving the LUT entries per logic element; FRAME_BITS = LUT_SIZE+1 (MODE bit + LUT data).
REQ-002 SHALL have parameter NUM_LE, default 4, giving the logic elements served; TOTAL = NUM_LE*FRAME_BITS (68 at defaults).
REQ-003 SHALL have clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-004 SHALL have nrst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have start, input, 1 bit: begin a load session.
REQ-006 SHALL have abort, input, 1 bit: cancel the session in progress.
REQ-007 SHALL have bit_in, input, 1 bit: serial bitstream data.
REQ-008 SHALL have bit_valid, input, 1 bit: bit_in is valid.
REQ-009 SHALL have bit_ready, output, 1 bit: loader accepts a bit this cycle.
REQ-010 SHALL have config_out, output, TOTAL bits: LE k receives config_out[k*FRAME_BITS +: FRAME_BITS], with the MSB of each frame as the MODE bit.
REQ-011 SHALL have cfg_valid, output, 1 bit: config_out holds a checked configuration; used as the LE enable.
REQ-012 SHALL have busy, output, 1 bit: session active.
REQ-013 SHALL have done, output, 1 bit: one-cycle pulse on successful commit.
REQ-014 SHALL have error, output, 1 bit: parity failure flag.

Function
REQ-015 SHALL transfer a bit only on a cycle where bit_valid && bit_ready; bits with bit_ready low are not consumed; bit_valid gaps SHALL NOT change any result.
REQ-016 SHALL implement the states IDLE, SYNC, LOAD, CHECK, DONE and ERR; bit_ready = busy = (state in SYNC, LOAD or CHECK), registered.
REQ-017 SHALL move from IDLE, DONE or ERR to SYNC on start; that edge SHALL clear cfg_valid and error and zero the sync window, bit counter and shadow register; start in SYNC, LOAD or CHECK SHALL be ignored.
REQ-018 In SYNC, SHALL shift each accepted bit into an 8-bit window (first bit received ends up as MSB); when the window equals 8'hA5 after a transfer, SHALL enter LOAD; overlapping and preceded-by-garbage patterns SHALL be detected.
REQ-019 In LOAD, SHALL shift each accepted bit into a TOTAL-bit shadow register from the LSB end, so that the first payload bit ends in shadow[TOTAL-1]; SHALL accumulate the XOR of payload bits; after the TOTAL-th payload bit, SHALL enter CHECK.
REQ-020 In CHECK, the next accepted bit is the parity bit; if it equals the XOR of the payload bits, then on that same edge config_out <= shadow, cfg_valid <= 1, state <= DONE, and done SHALL be high for exactly the next cycle.
REQ-021 On a parity mismatch, SHALL go to ERR with error = 1 held until start or reset; config_out SHALL remain unchanged and cfg_valid SHALL remain 0.
REQ-022 config_out SHALL change only on a successful commit (atomic update), never during SYNC, LOAD or CHECK.
REQ-023 abort SHALL take SYNC, LOAD or CHECK to IDLE on the next edge, discarding the shadow register; it SHALL leave config_out unchanged, leave cfg_valid 0, and assert neither done nor error; abort has priority over a same-cycle transfer; abort in IDLE, DONE or ERR has no effect.
REQ-024 start and abort asserted together in IDLE, DONE or ERR SHALL be treated as start.
REQ-025 The bit counter SHALL be sized for TOTAL and SHALL NOT wrap; bits after the parity bit are not accepted (bit_ready = 0 in DONE).

Reset
REQ-026 While nrst = 0: state = IDLE; config_out, the shadow register, window and counter = 0; cfg_valid, busy, bit_ready, done and error = 0.
REQ-027 Reset asserted mid-session SHALL abandon the session immediately (asynchronously), with no done or error pulse.
REQ-028 After nrst rises, the first state change SHALL occur on a clk edge with start = 1.

Verification
REQ-029 Reset: hold nrst = 0, then release -> all outputs 0, bit_ready = 0, state IDLE.
REQ-030 Good load: start, then 8'hA5, then 68 bits of 1, then parity 0 -> config_out = all 1s, cfg_valid = 1, done high for 1 cycle, error = 0.
REQ-031 Bad parity: after REQ-030, start, then A5, then 68 bits alternating 1,0 (first bit 1), then parity 1 -> error = 1, config_out still all 1s, cfg_valid = 0.
REQ-032 Sync search: start, then bits 1,1,0,1,0,1,0,0,1,0,1 (garbage, then A5), then a payload with LE0 frame = 17'h1_8000 and other frames 0, then correct parity -> config_out[16:0] = 17'h18000.
REQ-033 Flow control: same stimulus as REQ-030 with bit_valid toggling each cycle, plus start pulsed during LOAD -> identical result, start ignored.
REQ-034 Interruption: abort after 30 payload bits -> IDLE, config_out unchanged; repeat with nrst pulsed low after 30 bits -> all outputs 0.

Source files
------------

// File: rtl/le_config_loader_if.sv
// Serial bitstream handshake between a configuration source and the loader.
// The source drives bit_in/bit_valid; the loader answers with bit_ready.
interface le_config_loader_if;
  logic bit_in;
  logic bit_valid;
  logic bit_ready;

  modport master (
    output bit_in,
    output bit_valid,
    input  bit_ready
  );

  modport slave (
    input  bit_in,
    input  bit_valid,
    output bit_ready
  );
endinterface

// File: rtl/le_config_loader.sv
// Logic-element configuration loader.
// Hunts for the 8'hA5 sync byte in a serial bitstream, shifts TOTAL payload
// bits into a shadow register, checks an even-XOR parity bit, and only then
// copies the shadow into config_out in a single edge.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no session; waiting for start
// S_SYNC  | sliding 8-bit window searching for 8'hA5
// S_LOAD  | shifting payload bits into the shadow register
// S_CHECK | next accepted bit is the parity bit
// S_DONE  | last session committed; config_out is valid
// S_ERR   | last session failed parity; error held until start
module le_config_loader #(
  parameter  int LUT_SIZE   = 16,
  parameter  int NUM_LE     = 4,
  localparam int FRAME_BITS = LUT_SIZE + 1,
  localparam int TOTAL      = NUM_LE * FRAME_BITS
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 start,
  input  logic                 abort,
  le_config_loader_if.slave    bs,
  output logic [TOTAL-1:0]     config_out,
  output logic                 cfg_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int CW = $clog2(TOTAL + 1);
  localparam logic [7:0] SYNC_WORD = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_LOAD  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t           state_q,     state_d;
  logic [7:0]       window_q,    window_d;
  logic [TOTAL-1:0] shadow_q,    shadow_d;
  logic [TOTAL-1:0] config_q,    config_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic             parity_q,    parity_d;
  logic             cfg_valid_q, cfg_valid_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             error_q,     error_d;

  logic             accept;
  logic [7:0]       window_shift;

  // bit_ready is the registered busy flag, so a transfer is simply valid while busy
  assign accept       = bs.bit_valid && busy_q;
  assign window_shift = {window_q[6:0], bs.bit_in};

  // Next-state and datapath: start/abort handling, sync hunt, payload shift, parity commit
  always_comb begin
    state_d     = state_q;
    window_d    = window_q;
    shadow_d    = shadow_q;
    config_d    = config_q;
    cnt_d       = cnt_q;
    parity_d    = parity_q;
    cfg_valid_d = cfg_valid_q;
    error_d     = error_q;
    done_d      = 1'b0;

    if (busy_q && abort) begin
      // abort wins over any transfer in the same cycle; committed config is untouched
      state_d  = S_IDLE;
      window_d = '0;
      shadow_d = '0;
      cnt_d    = '0;
      parity_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_d     = S_SYNC;
            cfg_valid_d = 1'b0;
            error_d     = 1'b0;
            window_d    = '0;
            shadow_d    = '0;
            cnt_d       = '0;
            parity_d    = 1'b0;
          end
        end

        S_SYNC: begin
          if (accept) begin
            window_d = window_shift;
            if (window_shift == SYNC_WORD) begin
              state_d  = S_LOAD;
              cnt_d    = CW'(TOTAL);
              parity_d = 1'b0;
            end
          end
        end

        S_LOAD: begin
          if (accept) begin
            shadow_d = {shadow_q[TOTAL-2:0], bs.bit_in};
            parity_d = parity_q ^ bs.bit_in;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              state_d = S_CHECK;
            end
          end
        end

        S_CHECK: begin
          if (accept) begin
            if (bs.bit_in == parity_q) begin
              config_d    = shadow_q;
              cfg_valid_d = 1'b1;
              done_d      = 1'b1;
              state_d     = S_DONE;
            end else begin
              error_d = 1'b1;
              state_d = S_ERR;
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_SYNC) || (state_d == S_LOAD) || (state_d == S_CHECK);
  end

  // State and output registers; async reset abandons any session with no pulse
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      window_q    <= '0;
      shadow_q    <= '0;
      config_q    <= '0;
      cnt_q       <= '0;
      parity_q    <= 1'b0;
      cfg_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      window_q    <= window_d;
      shadow_q    <= shadow_d;
      config_q    <= config_d;
      cnt_q       <= cnt_d;
      parity_q    <= parity_d;
      cfg_valid_q <= cfg_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bs.bit_ready = busy_q;
  assign busy         = busy_q;
  assign config_out   = config_q;
  assign cfg_valid    = cfg_valid_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_le_config_loader.sv
// Directed bench for le_config_loader at default parameters (TOTAL = 68).
module tb_le_config_loader;

  localparam int TOTAL = 68;

  logic             clk;
  logic             nrst;
  logic             start;
  logic             abort;
  logic [TOTAL-1:0] config_out;
  logic             cfg_valid;
  logic             busy;
  logic             done;
  logic             error;

  int checks   = 0;
  int failures = 0;

  logic [TOTAL-1:0] all_ones;
  logic [TOTAL-1:0] le0_vec;

  le_config_loader_if bs ();

  le_config_loader dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .abort      (abort),
    .bs         (bs),
    .config_out (config_out),
    .cfg_valid  (cfg_valid),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drive one bit; gap idle cycles (valid low, inverted data) precede it
  task automatic send_bit(input logic b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      bs.bit_valid = 1'b0;
      bs.bit_in    = ~b;
    end
    @(negedge clk);
    bs.bit_in    = b;
    bs.bit_valid = 1'b1;
    n = 0;
    while (bs.bit_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      failures++;
      $display("FAIL bit_ready_timeout actual=%b required=1", bs.bit_ready);
    end
    @(posedge clk);
    #1;
    bs.bit_valid = 1'b0;
  endtask

  task automatic send_sync(input int gap);
    logic [7:0] s;
    s = 8'hA5;
    for (int i = 7; i >= 0; i--) send_bit(s[i], gap);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    bs.bit_in = 1'b0;
    bs.bit_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (config_out !== '0) begin failures++; $display("FAIL reset_config actual=%h required=0", config_out); end
    checks++;
    if ({cfg_valid, busy, bs.bit_ready, done, error} !== 5'b0) begin
      failures++; $display("FAIL reset_flags actual=%b required=00000", {cfg_valid, busy, bs.bit_ready, done, error});
    end
    @(negedge clk);
    nrst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cfg_valid, busy, bs.bit_ready, done, error} !== 5'b0 || config_out !== '0) begin
      failures++; $display("FAIL reset_release actual=%b required=00000", {cfg_valid, busy, bs.bit_ready, done, error});
    end
  endtask

  task automatic test_good_load();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || bs.bit_ready !== 1'b1) begin
      failures++; $display("FAIL good_busy_after_start actual=%b%b required=11", busy, bs.bit_ready);
    end
    send_sync(0);
    for (int i = 0; i < TOTAL; i++) send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    checks++;
    if (config_out !== all_ones) begin failures++; $display("FAIL good_config actual=%h required=%h", config_out, all_ones); end
    checks++;
    if ({cfg_valid, done, error, busy} !== 4'b1100) begin
      failures++; $display("FAIL good_flags actual=%b required=1100", {cfg_valid, done, error, busy});
    end
    // a bit offered in DONE must not be consumed and done must drop
    @(negedge clk);
    bs.bit_in = 1'b0;
    bs.bit_valid = 1'b1;
    @(posedge clk);
    #1;
    bs.bit_valid = 1'b0;
    checks++;
    if ({done, cfg_valid, bs.bit_ready} !== 3'b010 || config_out !== all_ones) begin
      failures++; $display("FAIL good_done_pulse actual=%b required=010", {done, cfg_valid, bs.bit_ready});
    end
  endtask

  task automatic test_bad_parity();
    pulse_start();
    checks++;
    if (cfg_valid !== 1'b0) begin failures++; $display("FAIL bad_start_clears_valid actual=%b required=0", cfg_valid); end
    send_sync(0);
    for (int i = 0; i < TOTAL; i++) begin
      send_bit((i % 2 == 0) ? 1'b1 : 1'b0, 0);
      if (i == 33) begin
        checks++;
        if (config_out !== all_ones || busy !== 1'b1) begin
          failures++; $display("FAIL bad_midload_config actual=%h required=%h", config_out, all_ones);
        end
      end
    end
    send_bit(1'b1, 0);
    checks++;
    if ({error, cfg_valid, done, busy} !== 4'b1000) begin
      failures++; $display("FAIL bad_flags actual=%b required=1000", {error, cfg_valid, done, busy});
    end
    checks++;
    if (config_out !== all_ones) begin failures++; $display("FAIL bad_config actual=%h required=%h", config_out, all_ones); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (error !== 1'b1) begin failures++; $display("FAIL bad_error_held actual=%b required=1", error); end
  endtask

  task automatic test_sync_search();
    logic [10:0] hunt;
    hunt = 11'b110_1010_0101;
    pulse_start();
    checks++;
    if (error !== 1'b0) begin failures++; $display("FAIL sync_start_clears_error actual=%b required=0", error); end
    for (int i = 10; i >= 0; i--) send_bit(hunt[i], 0);
    for (int i = TOTAL - 1; i >= 0; i--) send_bit(le0_vec[i], 0);
    send_bit(1'b0, 0);
    checks++;
    if (config_out !== le0_vec) begin failures++; $display("FAIL sync_config actual=%h required=%h", config_out, le0_vec); end
    checks++;
    if (config_out[16:0] !== 17'h18000 || cfg_valid !== 1'b1 || done !== 1'b1) begin
      failures++; $display("FAIL sync_le0_frame actual=%h required=18000", config_out[16:0]);
    end
  endtask

  task automatic test_flow_control();
    pulse_start();
    send_sync(1);
    for (int i = 0; i < TOTAL; i++) begin
      send_bit(1'b1, 1);
      if (i == 20) pulse_start();
    end
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL flow_before_parity actual=%b%b required=10", busy, done);
    end
    send_bit(1'b0, 1);
    checks++;
    if (config_out !== all_ones) begin failures++; $display("FAIL flow_config actual=%h required=%h", config_out, all_ones); end
    checks++;
    if ({cfg_valid, done, error} !== 3'b110) begin
      failures++; $display("FAIL flow_flags actual=%b required=110", {cfg_valid, done, error});
    end
  endtask

  task automatic test_abort();
    pulse_start();
    send_sync(0);
    for (int i = 0; i < 30; i++) send_bit(1'b0, 0);
    // abort coincides with a valid bit; abort must win
    @(negedge clk);
    abort = 1'b1;
    bs.bit_in = 1'b1;
    bs.bit_valid = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    bs.bit_valid = 1'b0;
    checks++;
    if ({busy, bs.bit_ready, cfg_valid, done, error} !== 5'b0) begin
      failures++; $display("FAIL abort_flags actual=%b required=00000", {busy, bs.bit_ready, cfg_valid, done, error});
    end
    checks++;
    if (config_out !== all_ones) begin failures++; $display("FAIL abort_config actual=%h required=%h", config_out, all_ones); end
    // start together with abort from IDLE counts as start
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL start_abort_together actual=%b required=1", busy); end
  endtask

  task automatic test_reset_midload();
    send_sync(0);
    for (int i = 0; i < 30; i++) send_bit(1'b1, 0);
    #2;
    nrst = 1'b0;
    #1;
    checks++;
    if (config_out !== '0) begin failures++; $display("FAIL rst_mid_config actual=%h required=0", config_out); end
    checks++;
    if ({busy, bs.bit_ready, cfg_valid, done, error} !== 5'b0) begin
      failures++; $display("FAIL rst_mid_flags actual=%b required=00000", {busy, bs.bit_ready, cfg_valid, done, error});
    end
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, cfg_valid, done, error} !== 4'b0 || config_out !== '0) begin
      failures++; $display("FAIL rst_mid_after actual=%b required=0000", {busy, cfg_valid, done, error});
    end
  endtask

  initial begin
    all_ones = '1;
    le0_vec  = '0;
    le0_vec[16:0] = 17'h18000;
    test_reset();
    test_good_load();
    test_bad_parity();
    test_sync_search();
    test_flow_control();
    test_abort();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
